elastic_pipe_reg: RTL and testbench

ELASTIC_PIPE_REG -- requirements
Module: elastic_pipe_reg

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_stage.sv | 37 +++
 rtl/elastic_pipe_reg.sv | 161 ++++++++++++++++
 tb/tb_elastic_pipe_reg.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the elastic pipeline register family.
// Provides the stage limit, skid size and occupancy width helper.
package pipe_pkg;

  localparam int MAX_DEPTH = 8;
  localparam int SKID_N    = 2;

  function automatic int occ_w(input int depth);
    return $clog2(depth + SKID_N + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic stage: valid bit plus payload register.
// Ports: clk_i, rst_ni, clr_i, load_i, valid_i/data_i in, valid_o/data_o out.
module pipe_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= valid_i;
    end
  end

  // Payload only moves on a real transfer.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !clr_i && load_i && valid_i) begin
      data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic valid/ready pipeline register, DEPTH stages, optional skid.
// Ports: clock, reset(n), flush, in_* / out_* handshakes, occupancy.
module elastic_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1,
  parameter int SKID   = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [occ_w(DEPTH)-1:0]  occupancy
);

  localparam int OCC_W = occ_w(DEPTH);

  logic              acc;
  logic              sk_rdy;
  logic              out_xfer;
  logic [DEPTH-1:0]  ld;
  logic [DEPTH-1:0]  upv;
  logic [DEPTH-1:0]  st_v;
  logic [DATA_W-1:0] upd  [DEPTH];
  logic [DATA_W-1:0] st_d [DEPTH];
  logic [OCC_W-1:0]  occ_q, occ_d;

  assign acc      = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // A stage may load when it, or anything downstream of it, has room.
  always_comb begin
    logic r;
    ld = '0;
    r  = sk_rdy;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r     = ~st_v[i] | r;
      ld[i] = r;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign upv[i] = acc;
      assign upd[i] = in_data;
    end else begin : g_body
      assign upv[i] = st_v[i-1];
      assign upd[i] = st_d[i-1];
    end
    pipe_stage #(
      .DATA_W (DATA_W)
    ) u_stage (
      .clk_i   (clock),
      .rst_ni  (reset),
      .clr_i   (flush),
      .load_i  (ld[i]),
      .valid_i (upv[i]),
      .data_i  (upd[i]),
      .valid_o (st_v[i]),
      .data_o  (st_d[i])
    );
  end

  if (SKID != 0) begin : g_skid
    logic [SKID_N-1:0] skv_q, skv_d;
    logic [DATA_W-1:0] skd_q [SKID_N];
    logic [DATA_W-1:0] skd_d [SKID_N];
    logic              rdy_q;
    logic              lv;
    logic              push;
    logic              pop;
    logic [DEPTH-1:0]  nv;

    assign lv        = st_v[DEPTH-1];
    assign sk_rdy    = ~skv_q[1];
    // Empty skid is bypassed so latency stays DEPTH.
    assign out_valid = skv_q[0] | lv;
    assign out_data  = skv_q[0] ? skd_q[0] : st_d[DEPTH-1];
    assign pop       = skv_q[0] & out_ready;
    assign push      = lv & sk_rdy & ~(~skv_q[0] & out_ready);
    assign in_ready  = rdy_q;

    always_comb begin
      skv_d = skv_q;
      skd_d = skd_q;
      if (pop) begin
        skv_d = {1'b0, skv_q[1]};
        if (skv_q[1]) begin
          skd_d[0] = skd_q[1];
        end
      end
      if (push) begin
        if (!skv_d[0]) begin
          skv_d[0] = 1'b1;
          skd_d[0] = st_d[DEPTH-1];
        end else begin
          skv_d[1] = 1'b1;
          skd_d[1] = st_d[DEPTH-1];
        end
      end
    end

    always_comb begin
      nv = st_v;
      for (int i = 0; i < DEPTH; i++) begin
        if (ld[i]) begin
          nv[i] = upv[i];
        end
      end
    end

    // in_ready is the chain-ready of next cycle, precomputed.
    always_ff @(posedge clock) begin
      if (!reset) begin
        skv_q <= '0;
        rdy_q <= 1'b0;
      end else if (flush) begin
        skv_q <= '0;
        rdy_q <= 1'b1;
      end else begin
        skv_q <= skv_d;
        rdy_q <= ~&nv | ~skv_d[1];
      end
    end

    always_ff @(posedge clock) begin
      skd_q <= skd_d;
    end
  end else begin : g_noskid
    assign sk_rdy    = out_ready;
    assign out_valid = st_v[DEPTH-1];
    assign out_data  = st_d[DEPTH-1];
    assign in_ready  = reset & ld[0];
  end

  always_comb begin
    occ_d = occ_q;
    if (acc && !out_xfer) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!acc && out_xfer) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed bench for elastic_pipe_reg in several configurations.
// A: D3/S0, B: D2/S0, C: D1/S1, D: D4/S0; shared clock and reset.
module tb_elastic_pipe_reg;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic a_fl, a_iv, a_ir, a_ov, a_or;
  logic [W-1:0] a_id, a_od;
  logic [2:0]   a_occ;
  logic b_fl, b_iv, b_ir, b_ov, b_or;
  logic [W-1:0] b_id, b_od;
  logic [2:0]   b_occ;
  logic c_fl, c_iv, c_ir, c_ov, c_or;
  logic [W-1:0] c_id, c_od;
  logic [1:0]   c_occ;
  logic d_fl, d_iv, d_ir, d_ov, d_or;
  logic [W-1:0] d_id, d_od;
  logic [2:0]   d_occ;

  elastic_pipe_reg #(.DATA_W(W), .DEPTH(3), .SKID(0)) u_a (
    .clock(clk), .reset(rst_n), .flush(a_fl),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .occupancy(a_occ));

  elastic_pipe_reg #(.DATA_W(W), .DEPTH(2), .SKID(0)) u_b (
    .clock(clk), .reset(rst_n), .flush(b_fl),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .occupancy(b_occ));

  elastic_pipe_reg #(.DATA_W(W), .DEPTH(1), .SKID(1)) u_c (
    .clock(clk), .reset(rst_n), .flush(c_fl),
    .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
    .occupancy(c_occ));

  elastic_pipe_reg #(.DATA_W(W), .DEPTH(4), .SKID(0)) u_d (
    .clock(clk), .reset(rst_n), .flush(d_fl),
    .in_valid(d_iv), .in_ready(d_ir), .in_data(d_id),
    .out_valid(d_ov), .out_ready(d_or), .out_data(d_od),
    .occupancy(d_occ));

  task automatic test_reset();
    rst_n = 1'b0;
    {a_fl, a_iv, a_or, b_fl, b_iv, b_or} = '0;
    {c_fl, c_iv, c_or, d_fl, d_iv, d_or} = '0;
    a_id = '0; b_id = '0; c_id = '0; d_id = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL rst_a_ov got=%b want=0", a_ov); end
    checks++; if (a_occ !== 3'd0) begin errors++; $display("FAIL rst_a_occ got=%0d want=0", a_occ); end
    checks++; if (a_ir !== 1'b0) begin errors++; $display("FAIL rst_a_ir got=%b want=0", a_ir); end
    checks++; if (c_ir !== 1'b0) begin errors++; $display("FAIL rst_c_ir got=%b want=0", c_ir); end
    checks++; if (c_ov !== 1'b0) begin errors++; $display("FAIL rst_c_ov got=%b want=0", c_ov); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL rel_a_ir got=%b want=1", a_ir); end
    @(negedge clk);
    #1;
    checks++; if (c_ir !== 1'b1) begin errors++; $display("FAIL rel_c_ir got=%b want=1", c_ir); end
    checks++; if (c_occ !== 2'd0) begin errors++; $display("FAIL rel_c_occ got=%0d want=0", c_occ); end
  endtask

  task automatic test_back_to_back();
    logic eov;
    int   eocc;
    int   outs;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      a_or = 1'b1;
      a_iv = (k < 10);
      a_id = W'(k + 1);
      #1;
      eov  = (k >= 3 && k < 13);
      outs = (k < 3) ? 0 : ((k - 3 > 10) ? 10 : k - 3);
      eocc = ((k < 10) ? k : 10) - outs;
      checks++; if (a_ov !== eov) begin errors++; $display("FAIL b2b_ov[%0d] got=%b want=%b", k, a_ov, eov); end
      if (eov) begin
        checks++; if (a_od !== W'(k - 2)) begin errors++; $display("FAIL b2b_od[%0d] got=%h want=%h", k, a_od, W'(k - 2)); end
      end
      checks++; if (a_occ !== 3'(eocc)) begin errors++; $display("FAIL b2b_occ[%0d] got=%0d want=%0d", k, a_occ, eocc); end
      checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL b2b_ir[%0d] got=%b want=1", k, a_ir); end
    end
    a_iv = 1'b0;
  endtask

  task automatic test_fill();
    @(negedge clk); b_or = 1'b0; b_iv = 1'b1; b_id = 16'h0011; #1;
    checks++; if (b_ir !== 1'b1) begin errors++; $display("FAIL fill_ir0 got=%b want=1", b_ir); end
    @(negedge clk); b_id = 16'h0022; #1;
    checks++; if (b_ir !== 1'b1) begin errors++; $display("FAIL fill_ir1 got=%b want=1", b_ir); end
    @(negedge clk); b_id = 16'h0033; #1;
    checks++; if (b_ir !== 1'b0) begin errors++; $display("FAIL fill_full_ir got=%b want=0", b_ir); end
    checks++; if (b_occ !== 3'd2) begin errors++; $display("FAIL fill_occ got=%0d want=2", b_occ); end
    checks++; if (b_od !== 16'h0011) begin errors++; $display("FAIL fill_od got=%h want=0011", b_od); end
    @(negedge clk); b_or = 1'b1; #1;
    checks++; if (b_ir !== 1'b1) begin errors++; $display("FAIL fill_pass_ir got=%b want=1", b_ir); end
    checks++; if (b_ov !== 1'b1) begin errors++; $display("FAIL fill_pass_ov got=%b want=1", b_ov); end
    @(negedge clk); b_or = 1'b0; b_iv = 1'b0; #1;
    checks++; if (b_occ !== 3'd2) begin errors++; $display("FAIL fill_after_occ got=%0d want=2", b_occ); end
    checks++; if (b_od !== 16'h0022) begin errors++; $display("FAIL fill_after_od got=%h want=0022", b_od); end
    checks++; if (b_ir !== 1'b0) begin errors++; $display("FAIL fill_after_ir got=%b want=0", b_ir); end
    @(negedge clk); b_or = 1'b1; #1;
    @(negedge clk); #1;
    checks++; if (b_od !== 16'h0033) begin errors++; $display("FAIL fill_drain_od got=%h want=0033", b_od); end
    @(negedge clk); #1;
    checks++; if (b_ov !== 1'b0) begin errors++; $display("FAIL fill_empty_ov got=%b want=0", b_ov); end
  endtask

  task automatic test_skid();
    logic [W-1:0] q[$];
    logic [15:0]  pat;
    logic         eir;
    logic         eov;
    int           n;
    pat = 16'hF7BD;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      c_iv = (k < 24) ? pat[k % 16] : 1'b0;
      c_or = (k < 24) ? k[0] : 1'b1;
      c_id = W'(16'h0100 + n);
      #1;
      eir = (q.size() != 3);
      eov = (q.size() != 0);
      checks++; if (c_ir !== eir) begin errors++; $display("FAIL skid_ir[%0d] got=%b want=%b", k, c_ir, eir); end
      checks++; if (c_ov !== eov) begin errors++; $display("FAIL skid_ov[%0d] got=%b want=%b", k, c_ov, eov); end
      checks++; if (c_occ !== 2'(q.size())) begin errors++; $display("FAIL skid_occ[%0d] got=%0d want=%0d", k, c_occ, q.size()); end
      if (eov) begin
        checks++; if (c_od !== q[0]) begin errors++; $display("FAIL skid_od[%0d] got=%h want=%h", k, c_od, q[0]); end
        if (c_or) void'(q.pop_front());
      end
      if (c_iv && eir) begin
        q.push_back(c_id);
        n++;
      end
    end
    c_iv = 1'b0;
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); a_or = 1'b0; a_iv = 1'b1; a_id = W'(16'h00A1 + k);
    end
    @(negedge clk);
    a_iv = 1'b1; a_id = 16'hDEAD; a_fl = 1'b1; a_or = 1'b1;
    #1;
    checks++; if (a_occ !== 3'd3) begin errors++; $display("FAIL fl_pre_occ got=%0d want=3", a_occ); end
    checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL fl_cur_ov got=%b want=1", a_ov); end
    checks++; if (a_od !== 16'h00A1) begin errors++; $display("FAIL fl_cur_od got=%h want=00a1", a_od); end
    checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL fl_cur_ir got=%b want=1", a_ir); end
    @(negedge clk); a_fl = 1'b0; a_iv = 1'b0; #1;
    checks++; if (a_occ !== 3'd0) begin errors++; $display("FAIL fl_occ got=%0d want=0", a_occ); end
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL fl_ov[%0d] got=%b od=%h want=0", k, a_ov, a_od); end
    end
  endtask

  task automatic test_bubble();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      d_or = 1'b0;
      d_iv = (k == 0) || (k >= 5);
      d_id = (k == 0) ? 16'h00B1 : W'(16'h00B2 + k - 5);
      #1;
      if (d_iv) begin
        checks++; if (d_ir !== 1'b1) begin errors++; $display("FAIL bub_ir[%0d] got=%b want=1", k, d_ir); end
      end
    end
    @(negedge clk); d_iv = 1'b0; #1;
    checks++; if (d_occ !== 3'd4) begin errors++; $display("FAIL bub_occ got=%0d want=4", d_occ); end
    checks++; if (d_ir !== 1'b0) begin errors++; $display("FAIL bub_ir_full got=%b want=0", d_ir); end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); d_or = 1'b1; #1;
      checks++; if (d_ov !== 1'b1) begin errors++; $display("FAIL bub_ov[%0d] got=%b want=1", j, d_ov); end
      checks++; if (d_od !== W'(16'h00B1 + j)) begin errors++; $display("FAIL bub_od[%0d] got=%h want=%h", j, d_od, W'(16'h00B1 + j)); end
    end
    @(negedge clk); #1;
    checks++; if (d_ov !== 1'b0) begin errors++; $display("FAIL bub_end_ov got=%b want=0", d_ov); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); a_or = 1'b0; a_iv = 1'b1; a_id = W'(16'h0071 + k);
    end
    @(negedge clk);
    a_iv = 1'b1; a_id = 16'h0099;
    #1;
    checks++; if (a_occ !== 3'd2) begin errors++; $display("FAIL rm_pre_occ got=%0d want=2", a_occ); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; a_iv = 1'b1; a_id = 16'h0055; a_or = 1'b1;
    #1;
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL rm_ov got=%b want=0", a_ov); end
    checks++; if (a_occ !== 3'd0) begin errors++; $display("FAIL rm_occ got=%0d want=0", a_occ); end
    checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL rm_ir got=%b want=1", a_ir); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); a_iv = 1'b0; #1;
      checks++; if (a_ov !== (k == 3)) begin errors++; $display("FAIL rm_lat_ov[%0d] got=%b want=%b", k, a_ov, (k == 3)); end
      if (k == 3) begin
        checks++; if (a_od !== 16'h0055) begin errors++; $display("FAIL rm_od got=%h want=0055", a_od); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_fill();
    test_skid();
    test_flush();
    test_bubble();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
